// File: rtl/harq_llr_combiner_if.sv
// HARQ LLR combiner bus: control, RDM stream and HARQ buffer ports.
// o_Sat_Count exists only when HARQ_LLR_SAT_CNT_EN is defined.
interface harq_llr_combiner_if #(
    parameter int unsigned LLR_W  = 6,
    parameter int unsigned LANES  = 16,
    parameter int unsigned ADDR_W = 12
);
    localparam int unsigned DATA_W = LLR_W * LANES;

    logic              i_Combine_Start;
    logic [15:0]       i_Combine_Ncb_Size;
    logic [ADDR_W-1:0] i_Harq_Base_Address;
    logic              i_First_Tx;
    logic              o_RDM_Data_Request;
    logic              i_RDM_Data_Valid;
    logic              i_RDM_Data_Comp;
    logic [DATA_W-1:0] i_RDM_Data_Content;
    logic              o_Harq_Rd_Enable;
    logic [ADDR_W-1:0] o_Harq_Rd_Address;
    logic [DATA_W-1:0] i_Harq_Rd_Data;
    logic              o_Harq_Wr_Enable;
    logic [ADDR_W-1:0] o_Harq_Wr_Address;
    logic [DATA_W-1:0] o_Harq_Wr_Data;
    logic              o_Combine_Busy;
    logic              o_Combine_Done;
    logic              o_Combine_Error;
`ifdef HARQ_LLR_SAT_CNT_EN
    logic [15:0]       o_Sat_Count;
`endif

    modport slave (
        input  i_Combine_Start, i_Combine_Ncb_Size, i_Harq_Base_Address, i_First_Tx,
        input  i_RDM_Data_Valid, i_RDM_Data_Comp, i_RDM_Data_Content, i_Harq_Rd_Data,
        output o_RDM_Data_Request, o_Harq_Rd_Enable, o_Harq_Rd_Address,
        output o_Harq_Wr_Enable, o_Harq_Wr_Address, o_Harq_Wr_Data,
        output o_Combine_Busy, o_Combine_Done, o_Combine_Error
`ifdef HARQ_LLR_SAT_CNT_EN
        , output o_Sat_Count
`endif
    );

    modport master (
        output i_Combine_Start, i_Combine_Ncb_Size, i_Harq_Base_Address, i_First_Tx,
        output i_RDM_Data_Valid, i_RDM_Data_Comp, i_RDM_Data_Content, i_Harq_Rd_Data,
        input  o_RDM_Data_Request, o_Harq_Rd_Enable, o_Harq_Rd_Address,
        input  o_Harq_Wr_Enable, o_Harq_Wr_Address, o_Harq_Wr_Data,
        input  o_Combine_Busy, o_Combine_Done, o_Combine_Error
`ifdef HARQ_LLR_SAT_CNT_EN
        , input o_Sat_Count
`endif
    );
endinterface

// File: rtl/harq_llr_combiner.sv
// HARQ soft-combiner: adds each RDM word into the HARQ buffer with symmetric saturation.
// Optional clipped-lane counter enabled by HARQ_LLR_SAT_CNT_EN.
module harq_llr_combiner #(
    parameter int unsigned LLR_W  = 6,
    parameter int unsigned LANES  = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic               i_core_clk,
    input  logic               i_rx_rstn,
    harq_llr_combiner_if.slave bus
);
    localparam int unsigned DATA_W  = LLR_W * LANES;
    localparam int unsigned REM_W   = $clog2(LANES);
    localparam int unsigned WCNT_W  = 16 - REM_W + 1;
    localparam int          LLR_MAX = (1 << (LLR_W - 1)) - 1;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RUN, ST_FLUSH, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   n_q, n_d, wcnt_q, wcnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                first_q, first_d;
    logic                flush_q, flush_d;
    logic                req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0]   s1_rdm_q, s1_rdm_d;
    logic [LANES-1:0]    s1_keep_q, s1_keep_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                start_acc_c, accept_c, last_c, rd_en_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [LANES-1:0]    keep_c;
    logic [DATA_W-1:0]   comb_data_c;

    // Lanes flagged keep carry the old value (or 0 on first transmission).
    function automatic logic [LLR_W-1:0] lane_val(input logic first, input logic keep,
                                                  input logic signed [LLR_W-1:0] old_l,
                                                  input logic signed [LLR_W-1:0] new_l);
        int s;
        if (keep) return first ? '0 : old_l;
        s = first ? int'(new_l) : int'(old_l) + int'(new_l);
        if (s > LLR_MAX)       s = LLR_MAX;
        else if (s < -LLR_MAX) s = -LLR_MAX;
        return LLR_W'(s);
    endfunction

    // Control FSM and word counting
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rem_d       = rem_q;
        base_d      = base_q;
        first_d     = first_q;
        wcnt_d      = wcnt_q;
        flush_d     = flush_q;
        err_d       = err_q;
        start_acc_c = 1'b0;
        accept_c    = 1'b0;
        last_c      = (wcnt_q == n_q - WCNT_W'(1));
        rd_addr_c   = base_q + ADDR_W'(wcnt_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.i_Combine_Start) begin
                    start_acc_c = 1'b1;
                    n_d     = WCNT_W'(bus.i_Combine_Ncb_Size[15:REM_W])
                            + WCNT_W'(bus.i_Combine_Ncb_Size[REM_W-1:0] != '0);
                    rem_d   = bus.i_Combine_Ncb_Size[REM_W-1:0];
                    base_d  = bus.i_Harq_Base_Address;
                    first_d = bus.i_First_Tx;
                    wcnt_d  = '0;
                    flush_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.i_RDM_Data_Valid) begin
                    if (wcnt_q < n_q) begin
                        accept_c = 1'b1;
                        wcnt_d   = wcnt_q + WCNT_W'(1);
                        if (last_c || bus.i_RDM_Data_Comp) state_d = ST_FLUSH;
                        if (bus.i_RDM_Data_Comp && !last_c) err_d = 1'b1;
                    end else begin
                        // Only reachable with N=0: word dropped, pass ends.
                        err_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.i_RDM_Data_Valid) err_d = 1'b1;
                flush_d = 1'b1;
                if (flush_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        for (int k = 0; k < int'(LANES); k++) begin
            keep_c[k] = last_c && (rem_q != '0) && (k >= int'(rem_q));
        end

        rd_en_c = accept_c && !first_q;

        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    // Two-stage datapath: capture RDM word alongside HARQ read, then combine and write.
    always_comb begin
        s1_vld_d  = accept_c;
        s1_addr_d = accept_c ? rd_addr_c : s1_addr_q;
        s1_rdm_d  = accept_c ? bus.i_RDM_Data_Content : s1_rdm_q;
        s1_keep_d = accept_c ? keep_c : s1_keep_q;

        comb_data_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            comb_data_c[k*LLR_W +: LLR_W] = lane_val(first_q, s1_keep_q[k],
                                                     bus.i_Harq_Rd_Data[k*LLR_W +: LLR_W],
                                                     s1_rdm_q[k*LLR_W +: LLR_W]);
        end

        wr_en_d   = s1_vld_q;
        wr_addr_d = s1_vld_q ? s1_addr_q : wr_addr_q;
        wr_data_d = s1_vld_q ? comb_data_c : wr_data_q;
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            rem_q     <= '0;
            base_q    <= '0;
            first_q   <= 1'b0;
            wcnt_q    <= '0;
            flush_q   <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_rdm_q  <= '0;
            s1_keep_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rem_q     <= rem_d;
            base_q    <= base_d;
            first_q   <= first_d;
            wcnt_q    <= wcnt_d;
            flush_q   <= flush_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_rdm_q  <= s1_rdm_d;
            s1_keep_q <= s1_keep_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.o_RDM_Data_Request = req_q;
    assign bus.o_Harq_Rd_Enable   = rd_en_c;
    assign bus.o_Harq_Rd_Address  = rd_en_c ? rd_addr_c : '0;
    assign bus.o_Harq_Wr_Enable   = wr_en_q;
    assign bus.o_Harq_Wr_Address  = wr_addr_q;
    assign bus.o_Harq_Wr_Data     = wr_data_q;
    assign bus.o_Combine_Busy     = busy_q;
    assign bus.o_Combine_Done     = done_q;
    assign bus.o_Combine_Error    = err_q;

`ifdef HARQ_LLR_SAT_CNT_EN
    localparam int unsigned CLIP_W = $clog2(LANES + 1);

    logic [15:0]       sat_q, sat_d;
    logic [CLIP_W-1:0] nclip_c;
    logic [16:0]       sat_sum_c;

    function automatic logic lane_clip(input logic first, input logic keep,
                                       input logic signed [LLR_W-1:0] old_l,
                                       input logic signed [LLR_W-1:0] new_l);
        int s;
        if (keep) return 1'b0;
        s = first ? int'(new_l) : int'(old_l) + int'(new_l);
        return (s > LLR_MAX) || (s < -LLR_MAX);
    endfunction

    // Clipped-lane count per pass, saturating at all-ones
    always_comb begin
        nclip_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            nclip_c = nclip_c + CLIP_W'(lane_clip(first_q, s1_keep_q[k],
                                                  bus.i_Harq_Rd_Data[k*LLR_W +: LLR_W],
                                                  s1_rdm_q[k*LLR_W +: LLR_W]));
        end
        sat_sum_c = 17'(sat_q) + 17'(nclip_c);
        sat_d     = sat_q;
        if (start_acc_c)   sat_d = '0;
        else if (s1_vld_q) sat_d = sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) sat_q <= '0;
        else            sat_q <= sat_d;
    end

    assign bus.o_Sat_Count = sat_q;
`endif
endmodule

// File: tb/tb_harq_llr_combiner.sv
// Self-checking bench for harq_llr_combiner: vector table plus reset / busy-start sequences.
module tb_harq_llr_combiner;
    localparam int unsigned LLR_W  = 6;
    localparam int unsigned LANES  = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = LLR_W * LANES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    harq_llr_combiner_if #(.LLR_W(LLR_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    harq_llr_combiner #(.LLR_W(LLR_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .i_core_clk (clk),
        .i_rx_rstn  (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [15:0] ncb;
        logic [11:0] base;
        logic        first;
        int          harq_v;
        int          rdm_v;
        int          alt;
        int          nsend;
        int          comp_idx;
        int          gap;
        int          poke;
        int          exp_wr;
        logic        exp_err;
        int          exp_sat;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int n_writes = 0;
    int last_wr_cyc = 0;
    exp_t q[$];
    logic [DATA_W-1:0] mem [0:4095];
    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] fill(input int v, input int alt);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < int'(LANES); k++)
            r[k*6 +: 6] = 6'((alt != 0 && (k % 2) == 1) ? -v : v);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] rdm,
                                                   input logic first, input int nvalid);
        logic [DATA_W-1:0] r;
        logic signed [5:0] o6, n6;
        int o, n, s;
        for (int k = 0; k < int'(LANES); k++) begin
            o6 = old[k*6 +: 6];
            n6 = rdm[k*6 +: 6];
            o = o6;
            n = n6;
            if (k >= nvalid) s = first ? 0 : o;
            else begin
                s = first ? n : o + n;
                if (s > 31)  s = 31;
                if (s < -31) s = -31;
            end
            r[k*6 +: 6] = 6'(s);
        end
        return r;
    endfunction

    always @(posedge clk) cycle++;

    // HARQ RAM model with one-cycle read latency
    always @(posedge clk)
        if (bus.o_Harq_Rd_Enable) bus.i_Harq_Rd_Data <= mem[bus.o_Harq_Rd_Address];

    // Write monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_Harq_Wr_Enable) begin
            n_writes++;
            last_wr_cyc = cycle;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h",
                         bus.o_Harq_Wr_Address, bus.o_Harq_Wr_Data);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 128'(bus.o_Harq_Wr_Address), 128'(e.addr));
                chk("wr_data", 128'(bus.o_Harq_Wr_Data), 128'(e.data));
            end
        end
    end

    task automatic pulse_start(input logic [15:0] ncb, input logic [11:0] base, input logic first);
        @(posedge clk) #1;
        bus.i_Combine_Start     = 1'b1;
        bus.i_Combine_Ncb_Size  = ncb;
        bus.i_Harq_Base_Address = base;
        bus.i_First_Tx          = first;
        @(posedge clk) #1;
        bus.i_Combine_Start     = 1'b0;
        bus.i_Combine_Ncb_Size  = '0;
        bus.i_Harq_Base_Address = '0;
        bus.i_First_Tx          = 1'b0;
        @(negedge clk);
        chk("req_pulse", 128'(bus.o_RDM_Data_Request), 128'(1));
        chk("busy_on_start", 128'(bus.o_Combine_Busy), 128'(1));
        chk("err_cleared", 128'(bus.o_Combine_Error), 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int n, rem, nvalid, start_wr;
        logic stopped, acc, got;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        n   = int'(v.ncb[15:4]) + ((v.ncb[3:0] != 4'd0) ? 1 : 0);
        rem = int'(v.ncb[3:0]);
        for (int w = 0; w < n; w++) begin
            a = v.base + 12'(w);
            mem[a] = fill(v.harq_v, v.alt);
        end
        start_wr = n_writes;
        pulse_start(v.ncb, v.base, v.first);
        stopped = 1'b0;
        for (int w = 0; w < v.nsend; w++) begin
            @(posedge clk) #1;
            d = fill(v.rdm_v, v.alt);
            bus.i_RDM_Data_Valid   = 1'b1;
            bus.i_RDM_Data_Content = d;
            bus.i_RDM_Data_Comp    = (w == v.comp_idx);
            bus.i_Combine_Start    = (w == 0 && v.poke != 0);
            bus.i_Harq_Base_Address = 12'hABC;
            bus.i_Combine_Ncb_Size  = 16'd16;
            bus.i_First_Tx          = (v.poke != 0);
            acc = !stopped && (w < n);
            a = v.base + 12'(w);
            if (acc) begin
                nvalid = (w == n - 1 && rem != 0) ? rem : 16;
                q.push_back('{addr: a, data: exp_word(mem[a], d, v.first, nvalid)});
                if (w == v.comp_idx || w == n - 1) stopped = 1'b1;
            end else begin
                stopped = 1'b1;
            end
            @(negedge clk);
            if (w == 0) chk("req_one_cycle", 128'(bus.o_RDM_Data_Request), 128'(0));
            chk("rd_en", 128'(bus.o_Harq_Rd_Enable), 128'(acc && !v.first));
            if (acc && !v.first) chk("rd_addr", 128'(bus.o_Harq_Rd_Address), 128'(a));
            bus.i_Combine_Start = 1'b0;
            for (int g = 0; g < v.gap; g++) begin
                @(posedge clk) #1;
                bus.i_RDM_Data_Valid = 1'b0;
                bus.i_RDM_Data_Comp  = 1'b0;
            end
        end
        @(posedge clk) #1;
        bus.i_RDM_Data_Valid    = 1'b0;
        bus.i_RDM_Data_Comp     = 1'b0;
        bus.i_Combine_Start     = 1'b0;
        bus.i_Harq_Base_Address = '0;
        bus.i_Combine_Ncb_Size  = '0;
        bus.i_First_Tx          = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.o_Combine_Done) got = 1'b1;
        end
        chk("done_seen", 128'(got), 128'(1));
        if (got) begin
            chk("busy_at_done", 128'(bus.o_Combine_Busy), 128'(0));
            chk("error_flag", 128'(bus.o_Combine_Error), 128'(v.exp_err));
            chk("write_count", 128'(n_writes - start_wr), 128'(v.exp_wr));
            if (v.exp_wr > 0) chk("done_latency", 128'(cycle - last_wr_cyc), 128'(2));
            chk("scoreboard_empty", 128'(q.size()), 128'(0));
`ifdef HARQ_LLR_SAT_CNT_EN
            chk("sat_count", 128'(bus.o_Sat_Count), 128'(v.exp_sat));
`endif
            @(negedge clk);
            chk("done_single_pulse", 128'(bus.o_Combine_Done), 128'(0));
        end
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},     128'(bus.o_RDM_Data_Request), 128'(0));
        chk({tag, "_rd_en"},   128'(bus.o_Harq_Rd_Enable), 128'(0));
        chk({tag, "_rd_addr"}, 128'(bus.o_Harq_Rd_Address), 128'(0));
        chk({tag, "_wr_en"},   128'(bus.o_Harq_Wr_Enable), 128'(0));
        chk({tag, "_wr_addr"}, 128'(bus.o_Harq_Wr_Address), 128'(0));
        chk({tag, "_wr_data"}, 128'(bus.o_Harq_Wr_Data), 128'(0));
        chk({tag, "_busy"},    128'(bus.o_Combine_Busy), 128'(0));
        chk({tag, "_done"},    128'(bus.o_Combine_Done), 128'(0));
        chk({tag, "_err"},     128'(bus.o_Combine_Error), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_Combine_Start     = 1'b0;
        bus.i_Combine_Ncb_Size  = '0;
        bus.i_Harq_Base_Address = '0;
        bus.i_First_Tx          = 1'b0;
        bus.i_RDM_Data_Valid    = 1'b0;
        bus.i_RDM_Data_Comp     = 1'b0;
        bus.i_RDM_Data_Content  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk) #1;
        rst_n = 1'b1;

        //          ncb     base     first harq rdm alt nsend comp gap poke wr err sat
        vecs[0] = '{16'd64, 12'h010, 1'b0,   5,   3, 0,  4,   -1,  0,  0,  4, 1'b0, 0};
        vecs[1] = '{16'd32, 12'h100, 1'b0,  20,  20, 1,  2,    1,  0,  0,  2, 1'b0, 32};
        vecs[2] = '{16'd40, 12'h200, 1'b1,   7,   9, 1,  3,    2,  0,  0,  3, 1'b0, 0};
        vecs[3] = '{16'd16, 12'h300, 1'b1,   0, -32, 0,  1,    0,  0,  0,  1, 1'b0, 16};
        vecs[4] = '{16'd48, 12'hFFE, 1'b0,  -4,  10, 0,  3,    2,  1,  1,  3, 1'b0, 0};
        vecs[5] = '{16'd80, 12'h050, 1'b0,   1,   1, 0,  2,    1,  0,  0,  2, 1'b1, 0};
        vecs[6] = '{16'd20, 12'h060, 1'b0, -20, -20, 0,  2,    1,  0,  0,  2, 1'b0, 20};
        vecs[7] = '{16'd0,  12'h070, 1'b0,   1,   1, 0,  1,   -1,  0,  0,  0, 1'b1, 0};
        vecs[8] = '{16'd32, 12'h080, 1'b0,   2,   2, 0,  3,   -1,  0,  0,  2, 1'b1, 0};

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a streaming pass
        pulse_start(16'd64, 12'h400, 1'b0);
        for (int w = 0; w < 2; w++) begin
            @(posedge clk) #1;
            bus.i_RDM_Data_Valid   = 1'b1;
            bus.i_RDM_Data_Content = fill(4, 0);
            @(negedge clk);
            chk("rst_seq_rd_en", 128'(bus.o_Harq_Rd_Enable), 128'(1));
            chk("rst_seq_rd_addr", 128'(bus.o_Harq_Rd_Address), 128'(12'h400 + 12'(w)));
        end
        @(posedge clk) #1;
        bus.i_RDM_Data_Valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        bus.i_RDM_Data_Valid = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk) #1;
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
